bus_arbiter_2to1: RTL and testbench

Shares one 32-bit memory bus between the core's instruction request port (I) and data request port (D). Sits between the core proxy's `ireq`/`dreq` outputs and the memory/cache side. Holds at most one transaction in flight, routes `addr_ok`/`data_ok` back only to the owning requester, and applies D-priority with an anti-starvation override for I.

---
 rtl/bus_arbiter_2to1.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1
// Shares one 32-bit memory bus between the instruction port (I) and the
// data port (D). Only one transaction is in flight at a time. D normally
// wins. I is forced through after STARVE_LIMIT consecutive D grants made
// while I was waiting.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   i_valid, i_addr             I request (always a 4-byte read)
//   i_addr_ok, i_data_ok        I handshakes
//   i_rdata                     I read data
//   d_valid, d_addr, d_size,
//   d_strobe, d_wdata           D request (strobe != 0 means write)
//   d_addr_ok, d_data_ok        D handshakes
//   d_rdata                     D read data
//   m_valid, m_addr, m_size,
//   m_strobe, m_wdata           downstream request
//   m_addr_ok, m_data_ok        downstream handshakes
//   m_rdata                     downstream read data
module bus_arbiter_2to1 #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    // The counter is 3 bits and saturates at 7, so larger limits clamp.
    localparam int          LIM_CLAMP = (STARVE_LIMIT > 7) ? 7 : STARVE_LIMIT;
    localparam logic [2:0]  LIMIT     = 3'(LIM_CLAMP);

    state_t     state;
    owner_t     owner;
    logic [2:0] starve_cnt;

    owner_t sel;   // combinational winner, only meaningful in IDLE
    owner_t cur;   // whoever the bus is currently serving

    always_comb begin
        sel = OWN_NONE;
        if (d_valid && !(i_valid && (starve_cnt >= LIMIT)))
            sel = OWN_D;
        else if (i_valid)
            sel = OWN_I;
    end

    // In IDLE the winner is forwarded in the same cycle (zero added latency).
    assign cur     = (state == IDLE) ? sel : owner;
    assign m_valid = ((state == IDLE) && (sel != OWN_NONE)) || (state == ADDR);

    always_comb begin
        m_addr   = 32'd0;
        m_size   = 3'd0;
        m_strobe = 4'd0;
        m_wdata  = 32'd0;
        case (cur)
            OWN_I: begin
                m_addr = i_addr;
                m_size = 3'b010;
            end
            OWN_D: begin
                m_addr   = d_addr;
                m_size   = d_size;
                m_strobe = d_strobe;
                m_wdata  = d_wdata;
            end
            default: ;
        endcase
    end

    // Handshakes only ever go to the requester being served; a stray
    // data_ok in IDLE with nobody selected reaches no one.
    assign i_addr_ok = m_addr_ok && m_valid && (cur == OWN_I);
    assign d_addr_ok = m_addr_ok && m_valid && (cur == OWN_D);
    assign i_data_ok = m_data_ok && (cur == OWN_I);
    assign d_data_ok = m_data_ok && (cur == OWN_D);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel != OWN_NONE) begin
                        owner <= sel;
                        if (m_addr_ok)
                            state <= m_data_ok ? IDLE : DATA;
                        else
                            state <= ADDR;
                        // Count only D grants that made a waiting I lose.
                        if (sel == OWN_D && i_valid)
                            starve_cnt <= (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
                        else
                            starve_cnt <= 3'd0;
                    end
                end
                ADDR: begin
                    if (m_addr_ok) begin
                        if (m_data_ok) begin
                            state <= IDLE;
                            owner <= OWN_NONE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1. Expected grants and responses are
// queued when stimulus is driven and checked when the DUT hands out
// addr_ok / data_ok.
module tb_bus_arbiter_2to1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [2:0]  d_size;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    bus_arbiter_2to1 #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size),
        .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [3:0]  strobe;
    } grant_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     nchk  = 0;
    int     nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_grant(input logic is_d, input logic [31:0] addr, input logic [3:0] strobe);
        grant_t g;
        g.is_d = is_d; g.addr = addr; g.strobe = strobe;
        grant_q.push_back(g);
    endtask

    task automatic push_resp(input logic is_d, input logic [31:0] rdata);
        resp_t r;
        r.is_d = is_d; r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    // Scoreboard: consume an expected entry whenever a handshake fires.
    task automatic monitor();
        grant_t g;
        resp_t  r;
        if (i_addr_ok && d_addr_ok)
            chk("addr_ok_both", 32'd1, 32'd0);
        if (i_data_ok && d_data_ok)
            chk("data_ok_both", 32'd1, 32'd0);
        if (i_addr_ok || d_addr_ok) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_grant", {31'd0, d_addr_ok}, 32'hFFFF_FFFF);
            end else begin
                g = grant_q.pop_front();
                chk("grant_side", {31'd0, d_addr_ok}, {31'd0, g.is_d});
                chk("grant_addr", m_addr, g.addr);
                chk("grant_strobe", {28'd0, m_strobe}, {28'd0, g.strobe});
            end
        end
        if (i_data_ok || d_data_ok) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {31'd0, d_data_ok}, 32'hFFFF_FFFF);
            end else begin
                r = resp_q.pop_front();
                chk("resp_side", {31'd0, d_data_ok}, {31'd0, r.is_d});
                chk("resp_rdata", r.is_d ? d_rdata : i_rdata, r.rdata);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_addr = 0;
        d_valid = 0; d_addr = 0; d_size = 0; d_strobe = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_m_addr"}, m_addr, 32'd0);
        chk({tag, "_m_misc"}, {21'd0, m_size, m_strobe, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    endtask

    string order;
    int    dn;

    initial begin
        idle_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;

        // reset state
        sample();
        chk_all_zero("reset");
        chk("reset_rdata", i_rdata | d_rdata, 32'd0);
        chk("reset_starve", {29'd0, dut.starve_cnt}, 32'd0);
        advance();

        // I-only fetch: addr_ok in cycle 0, data_ok in cycle 2
        i_valid = 1; i_addr = 32'hBFC0_0000; m_addr_ok = 1;
        push_grant(0, 32'hBFC0_0000, 4'h0);
        push_resp(0, 32'h1234_5678);
        sample();
        chk("i_only_valid", {31'd0, m_valid}, 32'd1);
        chk("i_only_size", {29'd0, m_size}, 32'd2);
        chk("i_only_d_ok", {30'd0, d_addr_ok, d_data_ok}, 32'd0);
        advance();
        i_valid = 0; i_addr = 0; m_addr_ok = 0;
        sample();
        chk("i_only_data_wait", {30'd0, m_valid, i_data_ok}, 32'd0);
        advance();
        m_data_ok = 1; m_rdata = 32'h1234_5678;
        sample();
        chk("i_only_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd2);
        advance();
        idle_inputs();

        // simultaneous I and D: D write wins, I follows after D completes
        i_valid = 1; i_addr = 32'hBFC0_0004;
        d_valid = 1; d_addr = 32'h8000_0010; d_size = 3'd2; d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
        m_addr_ok = 1;
        push_grant(1, 32'h8000_0010, 4'hF);
        sample();
        chk("both_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("both_i_not_acked", {31'd0, i_addr_ok}, 32'd0);
        advance();
        d_valid = 0; d_strobe = 0; d_wdata = 0; m_addr_ok = 0;
        sample();
        chk("both_no_i_in_data", {31'd0, m_valid}, 32'd0);
        advance();
        m_data_ok = 1; m_rdata = 32'hAAAA_5555;
        push_resp(1, 32'hAAAA_5555);
        sample();
        chk("both_no_i_same_cycle", {31'd0, m_valid}, 32'd0);
        advance();
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
        push_grant(0, 32'hBFC0_0004, 4'h0);
        push_resp(0, 32'h0BAD_F00D);
        sample();
        chk("both_i_granted", {31'd0, m_valid}, 32'd1);
        advance();
        idle_inputs();

        // address stall for 3 cycles with I waiting
        d_valid = 1; d_addr = 32'h8000_0020; d_size = 3'd2;
        i_valid = 1; i_addr = 32'hBFC0_0008;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_addr", m_addr, 32'h8000_0020);
            chk("stall_no_ack", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
            advance();
        end
        m_addr_ok = 1;
        push_grant(1, 32'h8000_0020, 4'h0);
        sample();
        advance();
        d_valid = 0; d_addr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hCAFE_BABE;
        push_resp(1, 32'hCAFE_BABE);
        sample();
        advance();
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0000_0F0F;
        push_grant(0, 32'hBFC0_0008, 4'h0);
        push_resp(0, 32'h0000_0F0F);
        sample();
        advance();
        idle_inputs();

        // same-cycle addr_ok + data_ok for D reads, back to back
        d_valid = 1; d_addr = 32'h8000_0030; d_size = 3'd2;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1111_2222;
        push_grant(1, 32'h8000_0030, 4'h0);
        push_resp(1, 32'h1111_2222);
        sample();
        chk("fast_d_both_ok", {30'd0, d_addr_ok, d_data_ok}, 32'd3);
        advance();
        d_addr = 32'h8000_0034; m_rdata = 32'h3333_4444;
        push_grant(1, 32'h8000_0034, 4'h0);
        push_resp(1, 32'h3333_4444);
        sample();
        chk("fast_d_next_accepted", {31'd0, d_addr_ok}, 32'd1);
        advance();
        idle_inputs();

        // anti-starvation: grant order D,D,D,D,I,D
        order = "DDDDID";
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            i_valid = (k <= 4); i_addr = 32'hBFC0_0010;
            d_valid = 1; d_size = 3'd2; d_addr = 32'h8000_0100 + 32'(dn * 4);
            m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h5000_0000 + 32'(k);
            if (order[k] == 8'h44) begin
                push_grant(1, d_addr, 4'h0);
                push_resp(1, m_rdata);
            end else begin
                push_grant(0, 32'hBFC0_0010, 4'h0);
                push_resp(0, m_rdata);
            end
            sample();
            if (k == 3) chk("starve_cnt_before", {29'd0, dut.starve_cnt}, 32'd3);
            if (k == 5) chk("starve_cnt_cleared", {29'd0, dut.starve_cnt}, 32'd0);
            advance();
            if (order[k] == 8'h44) dn++;
        end
        idle_inputs();

        // reset during DATA of an I fetch, then a late data_ok
        i_valid = 1; i_addr = 32'hBFC0_0020; m_addr_ok = 1;
        push_grant(0, 32'hBFC0_0020, 4'h0);
        sample();
        advance();
        idle_inputs();
        resetn = 0;
        sample();
        advance();
        resetn = 1; m_data_ok = 1; m_rdata = 32'h9999_9999;
        sample();
        chk_all_zero("late_data_ok");
        chk("late_rdata_passthru", i_rdata, 32'h9999_9999);
        advance();
        idle_inputs();

        sample();
        chk("grant_q_drained", grant_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
